// File: rtl/mips_pkg.sv
// Shared encodings for the five-stage MIPS32 subset pipeline: opcodes, functs,
// ALU operations, load/store size codes, pipeline register layouts and the program ROM.
package mips_pkg;

    localparam int NB              = 32;
    localparam int NB_SIZE_TYPE    = 3;
    localparam int TAM_DATA_MEMORY = 16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Load/store opcodes carry the size code {unsigned, size} in their low three bits.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        alu_op_t                 alu_op;
        logic [NB-1:0]           a;
        logic [NB-1:0]           b;
        logic [NB-1:0]           store_data;
        logic [4:0]              shamt;
        logic [4:0]              dest;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic [NB_SIZE_TYPE-1:0] size;
    } id_ex_t;

    typedef struct packed {
        logic [NB-1:0]           alu_result;
        logic [NB-1:0]           store_data;
        logic [4:0]              dest;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic [NB_SIZE_TYPE-1:0] size;
    } ex_mem_t;

    typedef struct packed {
        logic [NB-1:0] wb_data;
        logic [4:0]    dest;
        logic          reg_write;
    } mem_wb_t;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    // Program image; producers sit at least three words ahead of their consumers.
    function automatic logic [31:0] rom_word(input logic [4:0] idx);
        case (idx)
            5'd1:    return enc_i(OP_ADDI,  5'd1,  5'd7,  16'd3);
            5'd2:    return enc_i(OP_ANDI,  5'd3,  5'd2,  16'd1);
            5'd3:    return enc_i(OP_ORI,   5'd3,  5'd4,  16'd8);
            5'd4:    return enc_i(OP_XORI,  5'd3,  5'd5,  16'd3);
            5'd5:    return enc_i(OP_LUI,   5'd0,  5'd6,  16'h1234);
            5'd6:    return enc_i(OP_ORI,   5'd0,  5'd12, 16'h00FF);
            5'd7:    return enc_i(OP_SW,    5'd0,  5'd3,  16'd8);
            5'd9:    return enc_i(OP_SB,    5'd0,  5'd12, 16'd1);
            5'd10:   return enc_i(OP_LW,    5'd0,  5'd9,  16'd8);
            5'd11:   return enc_i(OP_LB,    5'd0,  5'd10, 16'd1);
            5'd12:   return enc_i(OP_LBU,   5'd0,  5'd11, 16'd1);
            5'd13:   return enc_r(5'd2,  5'd3,  5'd14, 5'd0, FN_SUB);
            5'd14:   return enc_r(5'd0,  5'd0,  5'd15, 5'd0, FN_NOR);
            5'd15:   return enc_r(5'd0,  5'd3,  5'd16, 5'd4, FN_SLL);
            5'd16:   return enc_r(5'd14, 5'd1,  5'd17, 5'd0, FN_SLT);
            5'd17:   return enc_r(5'd14, 5'd1,  5'd18, 5'd0, FN_SLTU);
            5'd18:   return enc_r(5'd3,  5'd14, 5'd19, 5'd0, FN_SRAV);
            5'd19:   return enc_i(OP_SH,    5'd0,  5'd15, 16'd6);
            5'd20:   return enc_i(OP_LHU,   5'd0,  5'd20, 16'd6);
            5'd21:   return enc_i(OP_LH,    5'd0,  5'd21, 16'd6);
            5'd22:   return enc_i(OP_ADDIU, 5'd14, 5'd23, 16'hFFFF);
            5'd23:   return 32'hFC16_0005;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the EX stage; shifts act on operand b.
module mips_alu
    import mips_pkg::*;
(
    input  logic [NB-1:0] a,
    input  logic [NB-1:0] b,
    input  logic [4:0]    shamt,
    input  alu_op_t       alu_op,
    output logic [NB-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(NB-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(NB-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_LUI:  result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mips_pipeline.sv
// Step-controlled five-stage MIPS32 subset core with instruction ROM, register file,
// data memory and combinational debug read ports.
module mips_pipeline
    import mips_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_step,
    input  logic [4:0]    i_debug_mips_register_number,
    input  logic [NB-1:0] i_debug_address,
    output logic [NB-1:0] o_mips_pc,
    output logic [NB-1:0] o_mips_alu_result,
    output logic [NB-1:0] o_mips_register_data,
    output logic [NB-1:0] o_mips_data_memory
);

    logic [NB-1:0] pc, if_id_instr;
    id_ex_t        id_ex, id_next;
    ex_mem_t       ex_mem, ex_next;
    mem_wb_t       mem_wb, mem_next;
    logic [NB-1:0] regs [32];
    logic [NB-1:0] dmem [TAM_DATA_MEMORY];

    // Register read with write-through of the value WB is committing this cycle.
    function automatic logic [NB-1:0] reg_read(input logic [4:0] idx,
                                               input logic [NB-1:0] stored,
                                               input mem_wb_t wb);
        if (idx == 5'd0)                       return '0;
        else if (wb.reg_write && wb.dest == idx) return wb.wb_data;
        else                                   return stored;
    endfunction

    logic [5:0]    op, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic [NB-1:0] rs_val, rt_val, sign_imm, zero_imm;

    assign {op, rs, rt, rd, shamt, funct} = if_id_instr;
    assign imm      = if_id_instr[15:0];
    assign sign_imm = {{16{imm[15]}}, imm};
    assign zero_imm = {16'h0000, imm};
    assign rs_val   = reg_read(rs, regs[rs], mem_wb);
    assign rt_val   = reg_read(rt, regs[rt], mem_wb);

    always_comb begin
        id_next            = '0;
        id_next.a          = rs_val;
        id_next.b          = rt_val;
        id_next.store_data = rt_val;
        id_next.shamt      = shamt;
        id_next.size       = op[2:0];
        case (op)
            OP_RTYPE: begin
                id_next.reg_write = 1'b1;
                id_next.dest      = rd;
                case (funct)
                    FN_SLL:          id_next.alu_op = ALU_SLL;
                    FN_SRL:          id_next.alu_op = ALU_SRL;
                    FN_SRA:          id_next.alu_op = ALU_SRA;
                    FN_SLLV: begin   id_next.alu_op = ALU_SLL; id_next.shamt = rs_val[4:0]; end
                    FN_SRLV: begin   id_next.alu_op = ALU_SRL; id_next.shamt = rs_val[4:0]; end
                    FN_SRAV: begin   id_next.alu_op = ALU_SRA; id_next.shamt = rs_val[4:0]; end
                    FN_ADD, FN_ADDU: id_next.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: id_next.alu_op = ALU_SUB;
                    FN_AND:          id_next.alu_op = ALU_AND;
                    FN_OR:           id_next.alu_op = ALU_OR;
                    FN_XOR:          id_next.alu_op = ALU_XOR;
                    FN_NOR:          id_next.alu_op = ALU_NOR;
                    FN_SLT:          id_next.alu_op = ALU_SLT;
                    FN_SLTU:         id_next.alu_op = ALU_SLTU;
                    default:         id_next.reg_write = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                id_next.alu_op    = (op == OP_SLTI)  ? ALU_SLT :
                                    (op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
                id_next.b         = sign_imm;
                id_next.reg_write = 1'b1;
                id_next.dest      = rt;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                id_next.alu_op    = (op == OP_ANDI) ? ALU_AND :
                                    (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                id_next.b         = zero_imm;
                id_next.reg_write = 1'b1;
                id_next.dest      = rt;
            end
            OP_LUI: begin
                id_next.alu_op    = ALU_LUI;
                id_next.b         = {imm, 16'h0000};
                id_next.reg_write = 1'b1;
                id_next.dest      = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                id_next.b         = sign_imm;
                id_next.reg_write = 1'b1;
                id_next.mem_read  = 1'b1;
                id_next.dest      = rt;
            end
            OP_SB, OP_SH, OP_SW: begin
                id_next.b         = sign_imm;
                id_next.mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    logic [NB-1:0] alu_result;

    mips_alu u_alu (
        .a      (id_ex.a),
        .b      (id_ex.b),
        .shamt  (id_ex.shamt),
        .alu_op (id_ex.alu_op),
        .result (alu_result)
    );

    assign ex_next = '{alu_result: alu_result, store_data: id_ex.store_data, dest: id_ex.dest,
                       reg_write: id_ex.reg_write, mem_read: id_ex.mem_read,
                       mem_write: id_ex.mem_write, size: id_ex.size};

    logic [3:0]    word_idx;
    logic [1:0]    offset;
    logic [NB-1:0] mem_word, store_word, load_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;

    assign word_idx  = ex_mem.alu_result[5:2];
    assign offset    = ex_mem.alu_result[1:0];
    assign mem_word  = dmem[word_idx];
    assign load_byte = mem_word[{offset, 3'b000} +: 8];
    assign load_half = mem_word[{offset[1], 4'b0000} +: 16];

    // Sub-word stores read-modify-write the addressed word in a single step.
    always_comb begin
        store_word = mem_word;
        load_data  = mem_word;
        case (ex_mem.size[1:0])
            SIZE_BYTE: begin
                store_word[{offset, 3'b000} +: 8] = ex_mem.store_data[7:0];
                load_data = ex_mem.size[2] ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
            end
            SIZE_HALF: begin
                store_word[{offset[1], 4'b0000} +: 16] = ex_mem.store_data[15:0];
                load_data = ex_mem.size[2] ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
            end
            default: store_word = ex_mem.store_data;
        endcase
    end

    assign mem_next = '{wb_data:   ex_mem.mem_read ? load_data : ex_mem.alu_result,
                        dest:      ex_mem.dest,
                        reg_write: ex_mem.reg_write};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc          <= '0;
            if_id_instr <= '0;
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
        end else if (i_step) begin
            pc          <= pc + NB'(4);
            if_id_instr <= rom_word(pc[6:2]);
            id_ex       <= id_next;
            ex_mem      <= ex_next;
            mem_wb      <= mem_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= NB'(i);
        end else if (i_step && mem_wb.reg_write && mem_wb.dest != 5'd0) begin
            regs[mem_wb.dest] <= mem_wb.wb_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < TAM_DATA_MEMORY; i++) dmem[i] <= '0;
        end else if (i_step && ex_mem.mem_write) begin
            dmem[word_idx] <= store_word;
        end
    end

    logic unused_debug_bits;
    assign unused_debug_bits = ^{i_debug_address[NB-1:6], i_debug_address[1:0]};

    assign o_mips_pc            = pc;
    assign o_mips_alu_result    = alu_result;
    assign o_mips_register_data = reg_read(i_debug_mips_register_number,
                                           regs[i_debug_mips_register_number], mem_wb);
    assign o_mips_data_memory   = dmem[i_debug_address[5:2]];

endmodule

// File: tb/tb_mips_pipeline.sv
// Scoreboard bench for mips_pipeline: stimulus queues expected debug-port values,
// a monitor process selects each debug view and compares.
module tb_mips_pipeline;

    localparam int K_PC  = 0;
    localparam int K_ALU = 1;
    localparam int K_REG = 2;
    localparam int K_MEM = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        step = 1'b0;
    logic [4:0]  dbg_reg = 5'd0;
    logic [31:0] dbg_addr = 32'd0;
    logic [31:0] pc_out, alu_out, reg_out, mem_out;

    int          exp_kind [$];
    logic [31:0] exp_sel  [$];
    logic [31:0] exp_val  [$];
    string       exp_name [$];
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          busy = 1'b0;

    mips_pipeline dut (
        .i_clk                        (clk),
        .i_reset                      (reset_n),
        .i_step                       (step),
        .i_debug_mips_register_number (dbg_reg),
        .i_debug_address              (dbg_addr),
        .o_mips_pc                    (pc_out),
        .o_mips_alu_result            (alu_out),
        .o_mips_register_data         (reg_out),
        .o_mips_data_memory           (mem_out)
    );

    always #5 clk = ~clk;

    // Monitor: drains the scoreboard on falling edges while the core is held.
    initial begin : monitor
        int          kind;
        logic [31:0] sel, want, got;
        string       name;
        forever begin
            @(negedge clk);
            while (exp_kind.size() > 0) begin
                busy = 1'b1;
                kind = exp_kind.pop_front();
                sel  = exp_sel.pop_front();
                want = exp_val.pop_front();
                name = exp_name.pop_front();
                if (kind == K_REG) dbg_reg = sel[4:0];
                if (kind == K_MEM) dbg_addr = sel;
                #1;
                case (kind)
                    K_PC:    got = pc_out;
                    K_ALU:   got = alu_out;
                    K_REG:   got = reg_out;
                    default: got = mem_out;
                endcase
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
                end
            end
            busy = 1'b0;
        end
    end

    task automatic check_output(input int kind, input logic [31:0] sel,
                                input logic [31:0] want, input string name);
        exp_kind.push_back(kind);
        exp_sel.push_back(sel);
        exp_val.push_back(want);
        exp_name.push_back(name);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_kind.size() > 0 || busy) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_kind.size());
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            step = 1'b1;
            @(posedge clk);
            #1;
            step = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_program();
        for (int s = 1; s <= 28; s++) begin
            apply_stimulus(1);
            case (s)
                3: begin
                    check_output(K_PC,  0, 32'd12, "pc_step3");
                    check_output(K_ALU, 0, 32'd4,  "alu_addi_ex");
                end
                4:  check_output(K_REG, 7, 32'd7,          "r7_before_wb");
                5:  check_output(K_REG, 7, 32'd4,          "r7_write_through");
                6:  check_output(K_REG, 7, 32'd4,          "r7_committed");
                15: check_output(K_ALU, 0, 32'hFFFF_FFFE,  "alu_sub_ex");
                17: check_output(K_ALU, 0, 32'd48,         "alu_sll_ex");
                default: ;
            endcase
            drain();
        end
        check_output(K_PC,  0,  32'd112,        "pc_after_run");
        check_output(K_REG, 2,  32'd1,          "andi_r2");
        check_output(K_REG, 4,  32'd11,         "ori_r4");
        check_output(K_REG, 5,  32'd0,          "xori_r5");
        check_output(K_REG, 6,  32'h1234_0000,  "lui_r6");
        check_output(K_REG, 9,  32'd3,          "lw_r9");
        check_output(K_REG, 10, 32'hFFFF_FFFF,  "lb_r10");
        check_output(K_REG, 11, 32'h0000_00FF,  "lbu_r11");
        check_output(K_REG, 14, 32'hFFFF_FFFE,  "sub_r14");
        check_output(K_REG, 15, 32'hFFFF_FFFF,  "nor_r15");
        check_output(K_REG, 16, 32'd48,         "sll_r16");
        check_output(K_REG, 17, 32'd1,          "slt_r17");
        check_output(K_REG, 18, 32'd0,          "sltu_r18");
        check_output(K_REG, 19, 32'hFFFF_FFFF,  "srav_r19");
        check_output(K_REG, 20, 32'h0000_FFFF,  "lhu_r20");
        check_output(K_REG, 21, 32'hFFFF_FFFF,  "lh_r21");
        check_output(K_REG, 22, 32'd22,         "unsupported_nop_r22");
        check_output(K_REG, 23, 32'hFFFF_FFFD,  "addiu_r23");
        check_output(K_REG, 0,  32'd0,          "r0_zero");
        check_output(K_MEM, 8,  32'd3,          "sw_word2");
        check_output(K_MEM, 0,  32'h0000_FF00,  "sb_word0");
        check_output(K_MEM, 4,  32'hFFFF_0000,  "sh_word1");
        check_output(K_MEM, 12, 32'd0,          "untouched_word3");
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_output(K_PC,  0, 32'd0, "reset_pc");
        check_output(K_REG, 5, 32'd5, "reset_r5");
        check_output(K_REG, 0, 32'd0, "reset_r0");
        check_output(K_ALU, 0, 32'd0, "reset_alu");
        check_output(K_MEM, 8, 32'd0, "reset_mem2");
        drain();

        run_program();

        repeat (5) @(posedge clk);
        #1;
        check_output(K_PC, 0, 32'd112, "hold_pc");
        drain();

        pulse_reset();
        apply_stimulus(3);
        check_output(K_PC, 0, 32'd12, "pre_abort_pc");
        drain();
        pulse_reset();
        check_output(K_PC,  0,  32'd0,  "abort_pc");
        check_output(K_REG, 7,  32'd7,  "abort_r7");
        check_output(K_REG, 14, 32'd14, "abort_r14");
        check_output(K_MEM, 8,  32'd0,  "abort_mem2");
        check_output(K_ALU, 0,  32'd0,  "abort_alu");
        drain();

        run_program();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
